// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target register-file front end
//
// Oversampled I2C responder. Decodes START/STOP, a 7-bit address, a register
// pointer byte and data bytes; presents writes as single-cycle strobes and
// serves reads from an external register file addressed by rd_addr.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   scl_i    bus SCL (asynchronous)
//   sda_i    bus SDA as seen on the pad (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release
//   wr_en    one-cycle write strobe, qualifies wr_addr/wr_data
//   wr_addr  register address of the write
//   wr_data  register data of the write
//   rd_addr  current register pointer
//   rd_data  register contents at rd_addr
//   busy     high from START to STOP while addressed
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic [7:0]             sr;
    logic [3:0]             bit_cnt;
    logic [7:0]             ptr;
    logic                   rw;
    logic                   mack;

    // Synchronizers reset to the idle-bus level so reset release never
    // manufactures a START or STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

    assign rd_addr = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            ptr     <= 8'h00;
            busy    <= 1'b0;
            sr      <= 8'h00;
            bit_cnt <= 4'd0;
            rw      <= 1'b0;
            mack    <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            // Bus conditions take priority over any SCL edge in the same cycle.
            if (start) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else if (stop) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            sr      <= {sr[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == ST_WDATA && bit_cnt == 4'd7) begin
                                wr_en   <= 1'b1;
                                wr_addr <= ptr;
                                wr_data <= {sr[6:0], sda_s};
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR) begin
                                // General call (all-zero address) is never acknowledged.
                                if (sr[7:1] == ADDR && sr[7:1] != 7'd0) begin
                                    sda_oe <= 1'b1;
                                    rw     <= sr[0];
                                    busy   <= 1'b1;
                                    state  <= ST_ADDR_ACK;
                                end else begin
                                    state  <= ST_IDLE;
                                end
                            end else if (state == ST_REG) begin
                                ptr    <= sr;
                                sda_oe <= 1'b1;
                                state  <= ST_REG_ACK;
                            end else begin
                                sda_oe <= 1'b1;
                                state  <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                // Releasing ACK and presenting the read MSB share this fall.
                                sr     <= {rd_data[6:0], 1'b0};
                                sda_oe <= ~rd_data[7];
                                state  <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_REG;
                            end
                        end
                    end
                    ST_REG_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WDATA;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            ptr    <= ptr + 8'd1;
                            state  <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                state   <= ST_RDATA_ACK;
                            end else begin
                                sda_oe <= ~sr[7];
                                sr     <= {sr[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        // Pointer advances on the ACK rise so rd_data has the
                        // whole high phase to settle before the next byte loads.
                        if (scl_rise) begin
                            mack <= sda_s;
                            ptr  <= ptr + 8'd1;
                        end else if (scl_fall) begin
                            if (!mack) begin
                                sr     <= {rd_data[6:0], 1'b0};
                                sda_oe <= ~rd_data[7];
                                state  <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard testbench for i2c_target
module tb_i2c_target;

    localparam time Q = 60ns;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       sda_pad;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;

    assign sda_pad = m_sda & ~sda_oe;
    assign rd_data = ~rd_addr;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h10), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_pad),
        .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe is matched against the expected-write queue.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=%0h:%0h expected=none", wr_addr, wr_data);
            end else begin
                check("wr_strobe", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;
        #Q m_scl = 1'b1;
        #Q s = sda_pad;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(ack, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;

        // Reset values
        #22;
        check("rst_sda_oe", {15'd0, sda_oe}, 16'h0);
        check("rst_wr_en", {15'd0, wr_en}, 16'h0);
        check("rst_wr_addr", {8'd0, wr_addr}, 16'h0);
        check("rst_wr_data", {8'd0, wr_data}, 16'h0);
        check("rst_rd_addr", {8'd0, rd_addr}, 16'h0);
        check("rst_busy", {15'd0, busy}, 16'h0);
        #20 rst = 1'b0;
        #100;

        // Basic write with auto-increment
        bus_start();
        wr_byte(8'h20, ack); check("wr_addr_ack", {15'd0, ack}, 16'h0);
        check("wr_busy", {15'd0, busy}, 16'h1);
        wr_byte(8'h05, ack); check("wr_reg_ack", {15'd0, ack}, 16'h0);
        exp_q.push_back(16'h05A5);
        wr_byte(8'hA5, ack); check("wr_d0_ack", {15'd0, ack}, 16'h0);
        exp_q.push_back(16'h063C);
        wr_byte(8'h3C, ack); check("wr_d1_ack", {15'd0, ack}, 16'h0);
        bus_stop();
        #100;
        check("wr_ptr", {8'd0, rd_addr}, 16'h0007);
        check("wr_busy_stop", {15'd0, busy}, 16'h0);

        // Address miss
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        bus_start();
        wr_byte(8'h22, ack); check("miss_addr_nack", {15'd0, ack}, 16'h1);
        wr_byte(8'h05, ack); check("miss_reg_nack", {15'd0, ack}, 16'h1);
        wr_byte(8'hFF, ack); check("miss_data_nack", {15'd0, ack}, 16'h1);
        bus_stop();
        #100;
        check("miss_oe_seen", {15'd0, oe_seen}, 16'h0);
        check("miss_busy_seen", {15'd0, busy_seen}, 16'h0);
        check("miss_ptr", {8'd0, rd_addr}, 16'h0007);

        // General call ignored
        bus_start();
        wr_byte(8'h00, ack); check("gcall_nack", {15'd0, ack}, 16'h1);
        bus_stop();

        // Read with repeated START
        bus_start();
        wr_byte(8'h20, ack); check("rd_waddr_ack", {15'd0, ack}, 16'h0);
        wr_byte(8'h02, ack); check("rd_reg_ack", {15'd0, ack}, 16'h0);
        bus_start();
        wr_byte(8'h21, ack); check("rd_raddr_ack", {15'd0, ack}, 16'h0);
        rd_byte(1'b0, d); check("rd_byte0", {8'd0, d}, 16'h00FD);
        rd_byte(1'b1, d); check("rd_byte1", {8'd0, d}, 16'h00FC);
        #100;
        check("rd_oe_after_nack", {15'd0, sda_oe}, 16'h0);
        bus_stop();
        #100;
        check("rd_ptr", {8'd0, rd_addr}, 16'h0004);

        // Pointer wrap
        bus_start();
        wr_byte(8'h20, ack);
        wr_byte(8'hFE, ack); check("wrap_reg_ack", {15'd0, ack}, 16'h0);
        exp_q.push_back(16'hFE11); wr_byte(8'h11, ack);
        exp_q.push_back(16'hFF22); wr_byte(8'h22, ack);
        exp_q.push_back(16'h0033); wr_byte(8'h33, ack);
        check("wrap_last_ack", {15'd0, ack}, 16'h0);
        bus_stop();
        #100;
        check("wrap_ptr", {8'd0, rd_addr}, 16'h0001);

        // STOP mid-byte discards the partial data
        bus_start();
        wr_byte(8'h20, ack);
        wr_byte(8'h40, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        bus_stop();
        #100;
        check("abort_oe", {15'd0, sda_oe}, 16'h0);
        check("abort_ptr", {8'd0, rd_addr}, 16'h0040);
        bus_start();
        wr_byte(8'h20, ack); check("abort_next_ack", {15'd0, ack}, 16'h0);
        wr_byte(8'h41, ack);
        exp_q.push_back(16'h4199); wr_byte(8'h99, ack);
        bus_stop();
        #100;
        check("abort_next_ptr", {8'd0, rd_addr}, 16'h0042);

        // Reset while ACK is driven
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(i == 5 ? 1'b1 : 1'b0, s);
        m_sda = 1'b1;
        check("rst_ack_driven", {15'd0, sda_oe}, 16'h1);
        #3 rst = 1'b1;
        #1;
        check("rst_async_oe", {15'd0, sda_oe}, 16'h0);
        check("rst_async_ptr", {8'd0, rd_addr}, 16'h0000);
        #20 rst = 1'b0;
        #40;
        bus_bit(1'b1, s);
        wr_byte(8'h05, ack); check("rst_ignore_nack", {15'd0, ack}, 16'h1);
        wr_byte(8'h66, ack);
        bus_stop();
        #100;
        check("rst_ignore_ptr", {8'd0, rd_addr}, 16'h0000);
        bus_start();
        wr_byte(8'h20, ack); check("rst_next_ack", {15'd0, ack}, 16'h0);
        wr_byte(8'h10, ack);
        exp_q.push_back(16'h1077); wr_byte(8'h77, ack);
        bus_stop();
        #100;
        check("rst_next_ptr", {8'd0, rd_addr}, 16'h0011);

        check("sb_drained", exp_q.size(), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the codec-configuration bus; the receiving end of our I2C write initiator.
- Used in-fabric as a register-file front end for bench models of the codec. Also usable as a control port when another master drives the bus.
- Oversamples SCL/SDA on the system clock and decodes START, STOP, address, register pointer and data bytes.
- Presents writes as single-cycle strobes and sources read data from an external register file.

Parameters:
- ADDR, 7'h10, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- scl_i  input  1  bus SCL, asynchronous.
- sda_i  input  1  bus SDA as seen on the pad, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  8  register address for wr_en.
- wr_data  output  8  data for wr_en.
- rd_addr  output  8  current register pointer, continuously driven.
- rd_data  input  8  register contents at rd_addr; combinational or stable one cycle after rd_addr changes.
- busy  output  1  high from START to STOP while addressed.

Behaviour:
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, pointer (rd_addr)=0, busy=0, state IDLE.
- Async reset mid-transfer aborts immediately with no partial write. After reset the block waits for the next START.
- Input conditioning: SYNC_STAGES flops per input plus one history flop. Edges are detected on the synchronized values.
- Clock-rate requirement: SCL high and low phases are each ≥4 clk cycles.
- START (SDA fall while SCL high) from any state goes to ADDR. Bit count clears and busy clears until the address matches. This also covers repeated START.
- STOP (SDA rise while SCL high) from any state goes to IDLE, with sda_oe=0 and busy=0. A partial byte is discarded.
- Data bits are sampled on the synchronized SCL rise, MSB first. sda_oe changes only on the synchronized SCL fall, one clk after the fall is detected.
- States:
  - IDLE: ignore bus except START.
  - ADDR: shift 8 bits. On match of bits[7:1]==ADDR, go to ADDR_ACK and latch the R/W bit; on mismatch, go to IDLE (no ACK).
  - ADDR_ACK: drive ACK for the 9th clock. Then go to REG if W, or RDATA if R; RDATA loads rd_data into the shift register on the same SCL fall that releases ACK.
  - REG: 8 bits become the pointer, then REG_ACK with ACK driven, then WDATA.
  - WDATA: after the 8th bit rises, assert wr_en for exactly one clk one cycle later, with wr_addr=pointer and wr_data=byte. Go to WDATA_ACK with ACK driven. Pointer increments on the ACK slot's SCL fall. Back to WDATA.
  - RDATA: drive sda_oe = ~bit, MSB first, on each SCL fall. After the 8th bit, release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample master ACK on SCL rise. Pointer increments regardless. ACK (0) returns to RDATA with the next rd_data loaded. NACK (1) goes to IDLE-wait with SDA released.
- ACK timing: sda_oe asserts on the SCL fall after the 8th bit and deasserts on the SCL fall after the 9th.
- Pointer wraps 8'hFF to 8'h00.
- General call (8'h00) is not acknowledged.
- A START or STOP coinciding with an SCL edge in the same clk: the START/STOP wins.
- Clock stretching is not supported.

Test Plan:
- Write: START, 0x20(W), 0x05, 0xA5, 0x3C, STOP -> ACK low on all four 9th clocks; wr_en pulses (0x05,0xA5) then (0x06,0x3C); rd_addr=0x07 after STOP.
- Address miss: START, 0x22, 0x05, 0xFF, STOP -> sda_oe never 1, no wr_en, busy stays 0, pointer unchanged.
- Read with repeated START: write pointer 0x02, Sr, 0x21(R); model returns ~rd_addr; master ACKs byte 1, NACKs byte 2 -> bus reads 0xFD, 0xFC; sda_oe=0 after NACK; rd_addr=0x04.
- Wrap: pointer 0xFE, write 0x11, 0x22, 0x33 -> writes at 0xFE, 0xFF, 0x00; pointer ends 0x01.
- Abort: STOP after 4 data bits -> no wr_en, state IDLE, sda_oe=0. Then a new full write transaction succeeds.
- Reset mid-ACK: assert rst while sda_oe=1 -> sda_oe=0 the same cycle asynchronously, pointer=0, and the block ignores the bus until the next START.
